// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit paths:
//   - rx_state_e    : byte receiver FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   - calc_bps_cnt  : system-clock cycles per bit (integer division)
//   - calc_half     : cycles to the middle of the start bit
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int calc_half(input int bps_cnt);
    return bps_cnt / 2;
  endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// -----------------------------------------------------------------------------
// uart_frame_rx_if
// Groups the serial line and the frame-level result of the receiver.
//   rxd        : UART line into the receiver (idle high)
//   rxd_data   : last complete frame, first byte in the top byte
//   rxd_valid  : one-cycle pulse when rxd_data is updated
//   frame_err  : one-cycle pulse when a byte or partial frame is discarded
// Modports:
//   master : the receiver (consumes rxd, drives the frame results)
//   slave  : the host side (drives rxd, consumes the frame results)
// -----------------------------------------------------------------------------
interface uart_frame_rx_if #(
  parameter int FRAME_BYTES = 11
);
  logic                     rxd;
  logic [8*FRAME_BYTES-1:0] rxd_data;
  logic                     rxd_valid;
  logic                     frame_err;

  modport master (
    input  rxd,
    output rxd_data,
    output rxd_valid,
    output frame_err
  );

  modport slave (
    output rxd,
    input  rxd_data,
    input  rxd_valid,
    input  frame_err
  );
endinterface

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// Two-flop synchroniser plus 8N1 byte receive FSM.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   rxd         : raw UART line (asynchronous, idle high)
//   byte_data   : last received byte (valid while byte_valid is high)
//   byte_valid  : one-cycle pulse, byte with a good stop bit received
//   byte_err    : one-cycle pulse, stop bit sampled low (byte discarded)
//   rx_idle     : FSM is in IDLE and no start edge is being taken this cycle
// Timing, with t0 the first cycle the synchronised line is seen low:
//   start sample t0+HALF-1, data bit k at t0+HALF-1+BPS_CNT*(k+1),
//   stop sample t0+HALF-1+9*BPS_CNT, byte_valid/byte_err one cycle later.
// -----------------------------------------------------------------------------
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 24_000_000,
  parameter int UART_BPS = 460800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err,
  output logic       rx_idle
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int HALF    = calc_half(BPS_CNT);
  localparam int CNT_W   = $clog2(BPS_CNT);

  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_s_q, rxd_s_d;
  logic             rxd_prev_q, rxd_prev_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             byte_err_q, byte_err_d;
  logic             start_edge;

  assign start_edge = (state_q == IDLE) && rxd_prev_q && !rxd_s_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can leave a latch behind.
    rxd_meta_d   = rxd;
    rxd_s_d      = rxd_meta_q;
    rxd_prev_d   = rxd_s_q;
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) begin
          // The counter holds cycles elapsed since t0, so t0 itself is count 0.
          state_d = START;
          cnt_d   = CNT_W'(1);
        end
      end

      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line already back high at mid-start is a glitch, not a byte.
          state_d   = rxd_s_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == CNT_W'(BPS_CNT - 1)) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_W'(BPS_CNT - 1)) begin
          cnt_d   = '0;
          // After a bad stop bit IDLE still needs a 1->0 edge to restart,
          // which implicitly waits for the line to return high first.
          state_d = IDLE;
          if (rxd_s_q) begin
            byte_valid_d = 1'b1;
          end else begin
            byte_err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q   <= 1'b1;
      rxd_s_q      <= 1'b1;
      rxd_prev_q   <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, whatever the statement order.
      rxd_meta_q   <= rxd_meta_d;
      rxd_s_q      <= rxd_s_d;
      rxd_prev_q   <= rxd_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign byte_err   = byte_err_q;
  assign rx_idle    = (state_q == IDLE) && !start_edge;

endmodule

// File: rtl/uart_frame_rx.sv
// -----------------------------------------------------------------------------
// uart_frame_rx
// Receives 8N1 UART bytes and assembles FRAME_BYTES of them into one word.
// Ports:
//   sys_clk, sys_rst_n : system clock, asynchronous active-low reset
//   bus (master)       : rxd in; rxd_data / rxd_valid / frame_err out
// Behaviour:
//   - each good byte shifts into the frame register from the low end, so the
//     first byte of a frame ends up in the top byte of rxd_data
//   - the FRAME_BYTES-th byte loads rxd_data and pulses rxd_valid
//   - a bad stop bit, or an idle gap of TIMEOUT_BITS bit periods inside a
//     frame, drops the partial frame and pulses frame_err
//   - rxd_data only changes on a complete frame
// -----------------------------------------------------------------------------
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 24_000_000,
  parameter int UART_BPS     = 460800,
  parameter int FRAME_BYTES  = 11,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_frame_rx_if.master bus
);

  localparam int BPS_CNT     = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam int FW          = 8 * FRAME_BYTES;
  localparam int BC_W        = $clog2(FRAME_BYTES);
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * BPS_CNT;
  localparam int IDLE_W      = $clog2(TIMEOUT_CYC);

  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_err;
  logic              rx_idle;

  logic [FW-1:0]     frame_q, frame_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [FW-1:0]     rxd_data_q, rxd_data_d;
  logic              rxd_valid_q, rxd_valid_d;
  logic              frame_err_q, frame_err_d;

  uart_byte_rx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_byte_rx (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .rxd        (bus.rxd),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .rx_idle    (rx_idle)
  );

  always_comb begin
    frame_d     = frame_q;
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = '0;
    rxd_data_d  = rxd_data_q;
    rxd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    // Inter-byte gap watchdog: only runs inside a frame while the line is
    // quiet; any start edge or byte in progress keeps it at zero.
    if (rx_idle && (byte_cnt_q != '0)) begin
      if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
        byte_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    // byte_valid/byte_err follow a STOP state, so the watchdog above is at
    // zero in those cycles and cannot fire alongside them.
    if (byte_valid) begin
      frame_d = {frame_q[FW-9:0], byte_data};
      if (byte_cnt_q == BC_W'(FRAME_BYTES - 1)) begin
        rxd_data_d  = frame_d;
        rxd_valid_d = 1'b1;
        byte_cnt_d  = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (byte_err) begin
      byte_cnt_d  = '0;
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // NOTE: the frame and output registers are flops, not RAM, and rxd_data must read 0 from reset, so they are reset too.
      frame_q     <= '0;
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      rxd_data_q  <= '0;
      rxd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      rxd_data_q  <= rxd_data_d;
      rxd_valid_q <= rxd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.rxd_data  = rxd_data_q;
  assign bus.rxd_valid = rxd_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Serial receive path for the frequency-meter board, the counterpart of the UART transmit block. It deserialises 8N1 UART at `UART_BPS` from `sys_clk` and assembles `FRAME_BYTES` consecutive bytes into one wide word. Each complete frame produces a single-cycle `rxd_valid` with the word on `rxd_data`. It sits beside the transmitter on the 24 MHz system clock and carries host-to-board commands, for example gate-time or display-mode settings.

## Interface
- `CLK_FREQ`, 24_000_000: `sys_clk` frequency in Hz.
- `UART_BPS`, 460800: baud rate.
- `FRAME_BYTES`, 11: bytes per frame; `rxd_data` is 8×`FRAME_BYTES` bits wide (88).
- `TIMEOUT_BITS`, 20: idle gap, in bit periods, that aborts a partial frame.
- `sys_clk`  in  1: system clock, the only clock in the block.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `rxd`  in  1: UART line, asynchronous to `sys_clk`, idle high.
- `rxd_data`  out  8×FRAME_BYTES: last complete frame. The first byte received sits in the top byte `[87:80]`. Bits within each byte are LSB-first on the line.
- `rxd_valid`  out  1: one-cycle pulse when `rxd_data` is updated.
- `frame_err`  out  1: one-cycle pulse when a byte or partial frame is discarded.

## Operation
- **Input synchroniser:** `rxd` passes through 2 flops, both reset to 1. Call the result `rxd_s`.
- **Bit period:** `BPS_CNT = CLK_FREQ/UART_BPS`, integer division (52). `HALF = BPS_CNT/2` (26).
- **Byte FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on a 1→0 transition of `rxd_s`. The bit counter clears.
  - START: at count `HALF-1`, sample `rxd_s`.
    - If 1, it was a false start: go back to IDLE with no error.
    - If 0, go to DATA.
  - DATA: sample every `BPS_CNT` cycles and shift right into the byte register, LSB first. After 8 samples go to STOP.
  - STOP: sample after `BPS_CNT` cycles.
    - If 1: pulse `byte_valid` on the next cycle.
    - If 0: framing error. Discard the byte, pulse `frame_err`, wait until `rxd_s` is 1, then return to IDLE.
- **Frame assembler:**
  - On each `byte_valid`, shift the byte into the frame shift register from the low end and increment `byte_cnt`.
  - On the `FRAME_BYTES`-th byte: load `rxd_data`, pulse `rxd_valid`, clear `byte_cnt`.
- **Timeout:**
  - While `byte_cnt` ≠ 0 and the FSM is in IDLE, an idle counter runs.
  - When it reaches `TIMEOUT_BITS×BPS_CNT` (1040 cycles): clear `byte_cnt`, pulse `frame_err`.
  - The counter clears on any start edge.
- **Framing error mid-frame:** also clears `byte_cnt`. A frame is never completed across a framing error.
- **Held output:** `rxd_data` keeps its value until the next complete frame. Partial frames never modify it.

## Timing
- **Reset values:** `rxd_data`=0, `rxd_valid`=0, `frame_err`=0, FSM=IDLE, `byte_cnt`=0, all counters 0.
- **Reset mid-byte or mid-frame:** everything returns to the reset state immediately. The first falling edge after release starts a fresh frame.
- **Sample points:** take t0 as the cycle in which `rxd_s` is first seen low.
  - Start sample: t0+25.
  - Data bit k: t0+25+52(k+1).
  - Stop sample: t0+493.
  - `byte_valid`: t0+494.
  - `rxd_valid` for the last byte of a frame: t0+495.
- **Pin-to-`rxd_s` delay:** 2 cycles.
- **Rate:** back-to-back bytes at full line rate, with the next start edge 1 bit after stop, are received without loss.
- **Simultaneous events:** a timeout and a `byte_valid` cannot coincide, because the timeout counts only in IDLE with no start pending. `frame_err` and `rxd_valid` never pulse in the same cycle.

## Structure
- **Shared package `uart_pkg`:** `BPS_CNT`/`HALF` derivation function, FSM state encoding (2-bit localparams IDLE=0, START=1, DATA=2, STOP=3). The transmitter reuses the same baud derivation.
- **Sub-module `uart_byte_rx`:** synchroniser plus the byte FSM, with outputs `byte_data[7:0]`, `byte_valid` and `byte_err`.
- **Top of `uart_frame_rx`:** frame shift register, `byte_cnt`, timeout counter, output registers.
- **Expected size:** about 200 lines of RTL in total.

## Test plan
- **Single frame:** after reset, send 11 bytes 0x01..0x0B at 460800 baud with 1 idle bit between bytes → exactly one `rxd_valid`, `rxd_data` = 0x0102030405060708090A0B, `frame_err` never asserted.
- **Glitch rejection:** 10-cycle low glitch on an idle line → no state change, no pulses, `rxd_data` unchanged.
- **Framing error:** send 5 bytes, then byte 0x55 with stop bit forced low, then 11 bytes 0xA0..0xAA → one `frame_err` pulse, then `rxd_valid` with 0xA0A1…AA. Nothing from the first 5 bytes appears.
- **Timeout:** send 3 bytes, idle 1100 cycles, then send 11 bytes of 0xFF → one `frame_err` about 1040 cycles after the third byte's stop, then a valid frame of all-ones.
- **Reset mid-frame:** pulse `sys_rst_n` low for 3 cycles during byte 6 → outputs read 0 during reset. The next full frame is received correctly.
- **Baud tolerance:** repeat the single-frame test with the line at +2% and −2% baud → identical `rxd_data`, no errors.
